// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic accumulator stage.
// Default-width saturation limits are provided alongside the state and mode encodings.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   localparam int ACC_WD_DEF = 12;

   localparam logic signed [ACC_WD_DEF-1:0] SAT_MAX_DEF = {1'b0, {(ACC_WD_DEF-1){1'b1}}};
   localparam logic signed [ACC_WD_DEF-1:0] SAT_MIN_DEF = {1'b1, {(ACC_WD_DEF-1){1'b0}}};

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Width of the intermediate sum used before clamping.
   function automatic int sum_width(input int acc_wd);
      return acc_wd + 1;
   endfunction

endpackage

// File: rtl/arith_sat_add.sv
// Combinational saturating signed adder: sum formed one bit wider, then clamped
// to the representable range of ACC_WD bits.
module arith_sat_add
   import arith_pkg::*;
#(
   parameter int ACC_WD = 12
) (
   input  logic signed [ACC_WD-1:0] acc,
   input  logic signed [ACC_WD-1:0] addend,
   output logic signed [ACC_WD-1:0] sum,
   output logic                     sat
);

   localparam int SUM_WD = sum_width(ACC_WD);
   localparam logic signed [ACC_WD-1:0] SAT_MAX = {1'b0, {(ACC_WD-1){1'b1}}};
   localparam logic signed [ACC_WD-1:0] SAT_MIN = {1'b1, {(ACC_WD-1){1'b0}}};

   logic [SUM_WD-1:0] wide;

   always_comb begin
      wide = {acc[ACC_WD-1], acc} + {addend[ACC_WD-1], addend};
      sum  = wide[ACC_WD-1:0];
      sat  = 1'b0;
      // Top two bits disagree only when the true sum left the ACC_WD range.
      if (wide[SUM_WD-1] != wide[SUM_WD-2]) begin
         sat = 1'b1;
         sum = wide[SUM_WD-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/arith_accum.sv
// Frame accumulator: sums a programmed number of add/sub results into a saturating
// signed register, counts overflow-flagged samples, and hands the result downstream.
module arith_accum
   import arith_pkg::*;
#(
   parameter int DATA_WD = 4,
   parameter int ACC_WD  = 12,
   parameter int CNT_WD  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [CNT_WD-1:0]    i_len,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DATA_WD:0]     i_arith,
   input  logic                 i_ovr,
   input  logic                 i_mode,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [ACC_WD-1:0]    o_acc,
   output logic                 o_sat,
   output logic [CNT_WD-1:0]    o_ovr_cnt,
   output logic                 o_busy
);

   acc_state_t               state_reg;
   logic [CNT_WD-1:0]        len_reg;
   logic [CNT_WD-1:0]        cnt_reg;
   logic [CNT_WD-1:0]        ovr_cnt_reg;
   logic signed [ACC_WD-1:0] acc_reg;
   logic                     sat_reg;

   logic signed [ACC_WD-1:0] ext_sample;
   logic signed [ACC_WD-1:0] sum_next;
   logic                     sat_hit;
   logic                     sign_fill;
   logic                     accept;
   logic                     last_sample;

   // Add-mode results are unsigned magnitudes; sub-mode results are two's complement.
   assign sign_fill  = i_arith[DATA_WD] & (i_mode == MODE_SUB);
   assign ext_sample = {{(ACC_WD-DATA_WD-1){sign_fill}}, i_arith};

   arith_sat_add #(.ACC_WD(ACC_WD)) u_sat_add (
      .acc    (acc_reg),
      .addend (ext_sample),
      .sum    (sum_next),
      .sat    (sat_hit)
   );

   assign accept      = i_valid && (state_reg == ACCUM);
   assign last_sample = (cnt_reg == (len_reg - CNT_WD'(1)));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         len_reg     <= '0;
         cnt_reg     <= '0;
         ovr_cnt_reg <= '0;
         acc_reg     <= '0;
         sat_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_start && (i_len != '0)) begin
                  len_reg     <= i_len;
                  cnt_reg     <= '0;
                  ovr_cnt_reg <= '0;
                  acc_reg     <= '0;
                  sat_reg     <= 1'b0;
                  state_reg   <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_reg     <= sum_next;
                  sat_reg     <= sat_reg | sat_hit;
                  ovr_cnt_reg <= ovr_cnt_reg + {{(CNT_WD-1){1'b0}}, i_ovr};
                  cnt_reg     <= cnt_reg + CNT_WD'(1);
                  if (last_sample) begin
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               // A start coinciding with the handshake is dropped; IDLE sees the next one.
               if (i_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign o_ready   = (state_reg == ACCUM);
   assign o_valid   = (state_reg == DONE);
   assign o_busy    = (state_reg != IDLE);
   assign o_acc     = acc_reg;
   assign o_sat     = sat_reg;
   assign o_ovr_cnt = ovr_cnt_reg;

endmodule

// File: tb/tb_arith_accum.sv
// Self-checking bench for arith_accum (DATA_WD=4, ACC_WD=8, CNT_WD=4) using an
// expected-result queue filled while samples are driven.
module tb_arith_accum;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] len_in;
   logic       valid;
   logic       ready_out;
   logic [4:0] arith;
   logic       ovr;
   logic       mode;
   logic       valid_out;
   logic       ready_in;
   logic [7:0] acc_out;
   logic       sat_out;
   logic [3:0] ovr_cnt_out;
   logic       busy_out;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] acc;
      logic       sat;
      logic [3:0] ovr_cnt;
   } res_t;

   res_t exp_q[$];

   logic [4:0] s_arith[16];
   logic       s_ovr[16];
   logic       s_mode[16];

   arith_accum #(.DATA_WD(4), .ACC_WD(8), .CNT_WD(4)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_len     (len_in),
      .i_valid   (valid),
      .o_ready   (ready_out),
      .i_arith   (arith),
      .i_ovr     (ovr),
      .i_mode    (mode),
      .o_valid   (valid_out),
      .i_ready   (ready_in),
      .o_acc     (acc_out),
      .o_sat     (sat_out),
      .o_ovr_cnt (ovr_cnt_out),
      .o_busy    (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_idle_zero(input string name);
      checks++;
      if ({ready_out, valid_out, busy_out, acc_out, sat_out, ovr_cnt_out} !== 16'h0) begin
         errors++;
         $display("FAIL %s: ready=%b valid=%b busy=%b acc=%h sat=%b ovr=%h, expected all 0",
                  name, ready_out, valid_out, busy_out, acc_out, sat_out, ovr_cnt_out);
      end
   endtask

   // Drives a frame of len samples from s_* arrays; model result is queued once all are driven.
   task automatic drive_frame(input int len, input bit gaps);
      int  acc_m;
      bit  sat_m;
      int  oc_m;
      int  v;
      int  i;
      res_t r;
      acc_m = 0; sat_m = 0; oc_m = 0;
      @(negedge clk);
      start = 1'b1; len_in = 4'(len);
      @(negedge clk);
      start = 1'b0; len_in = 4'hF;
      checks++;
      if (ready_out !== 1'b1 || busy_out !== 1'b1) begin
         errors++;
         $display("FAIL start_ready: ready=%b busy=%b, expected 1 1", ready_out, busy_out);
      end
      i = 0;
      while (i < len) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            valid = 1'b0;
            arith = 5'($urandom);
            ovr   = 1'($urandom);
         end else begin
            valid = 1'b1;
            arith = s_arith[i];
            ovr   = s_ovr[i];
            mode  = s_mode[i];
            v = s_mode[i] ? int'($signed(s_arith[i])) : int'(s_arith[i]);
            acc_m = acc_m + v;
            if (acc_m > 127) begin acc_m = 127; sat_m = 1; end
            else if (acc_m < -128) begin acc_m = -128; sat_m = 1; end
            oc_m = (oc_m + int'(s_ovr[i])) % 16;
            i++;
         end
         @(negedge clk);
      end
      valid = 1'b0;
      r.acc = 8'(acc_m); r.sat = sat_m; r.ovr_cnt = 4'(oc_m);
      exp_q.push_back(r);
      checks++;
      if (valid_out !== 1'b1) begin
         errors++;
         $display("FAIL valid_latency: o_valid=%b one cycle after last accept, expected 1", valid_out);
      end
   endtask

   // Waits for a result, compares it to the queue head, then holds it for `hold` cycles.
   task automatic collect_result(input string name, input int hold, input bit start_pulse);
      int   n;
      res_t e;
      res_t got;
      n = 0;
      while (valid_out !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (valid_out !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: o_valid never rose, expected 1", name);
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_scoreboard: result with empty queue", name);
         return;
      end
      e = exp_q.pop_front();
      got = '{acc: acc_out, sat: sat_out, ovr_cnt: ovr_cnt_out};
      $display("frame %s: acc=%h sat=%b ovr_cnt=%0d (expected acc=%h sat=%b ovr_cnt=%0d)",
               name, got.acc, got.sat, got.ovr_cnt, e.acc, e.sat, e.ovr_cnt);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s_result: acc=%h sat=%b ovr=%0d, expected acc=%h sat=%b ovr=%0d",
                  name, got.acc, got.sat, got.ovr_cnt, e.acc, e.sat, e.ovr_cnt);
      end
      for (int h = 0; h < hold; h++) begin
         ready_in = 1'b0;
         if (start_pulse) begin start = 1'b1; len_in = 4'd1; end
         @(negedge clk);
         checks++;
         if (valid_out !== 1'b1 || ready_out !== 1'b0 || acc_out !== e.acc ||
             sat_out !== e.sat || ovr_cnt_out !== e.ovr_cnt) begin
            errors++;
            $display("FAIL %s_hold%0d: valid=%b ready=%b acc=%h sat=%b ovr=%0d, expected 1 0 %h %b %0d",
                     name, h, valid_out, ready_out, acc_out, sat_out, ovr_cnt_out,
                     e.acc, e.sat, e.ovr_cnt);
         end
      end
      ready_in = 1'b1;
      start = start_pulse;
      len_in = 4'd1;
      @(negedge clk);
      ready_in = 1'b0;
      start = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL %s_release: valid=%b busy=%b after handshake, expected 0 0",
                  name, valid_out, busy_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_zero("reset_state");
      start = 1'b1; len_in = 4'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_idle_zero("start_len0");
   endtask

   task automatic test_basic();
      s_arith[0] = 5'd17; s_ovr[0] = 1'b1; s_mode[0] = 1'b0;
      s_arith[1] = 5'd30; s_ovr[1] = 1'b1; s_mode[1] = 1'b0;
      s_arith[2] = 5'd3;  s_ovr[2] = 1'b0; s_mode[2] = 1'b0;
      drive_frame(3, 1'b0);
      checks++;
      if (acc_out !== 8'd50 || ovr_cnt_out !== 4'd2) begin
         errors++;
         $display("FAIL basic_const: acc=%0d ovr=%0d, expected 50 2", acc_out, ovr_cnt_out);
      end
      collect_result("basic", 0, 1'b0);
   endtask

   task automatic test_signed();
      s_arith[0] = 5'b11101; s_ovr[0] = 1'b0; s_mode[0] = 1'b1;
      s_arith[1] = 5'b00100; s_ovr[1] = 1'b0; s_mode[1] = 1'b1;
      drive_frame(2, 1'b0);
      checks++;
      if (acc_out !== 8'd1) begin
         errors++;
         $display("FAIL signed_const: acc=%h, expected 01", acc_out);
      end
      collect_result("signed", 0, 1'b0);
      s_arith[0] = 5'd16;    s_ovr[0] = 1'b1; s_mode[0] = 1'b0;
      s_arith[1] = 5'b10000; s_ovr[1] = 1'b0; s_mode[1] = 1'b1;
      drive_frame(2, 1'b0);
      checks++;
      if (acc_out !== 8'd0) begin
         errors++;
         $display("FAIL mixed_const: acc=%h, expected 00", acc_out);
      end
      collect_result("mixed", 0, 1'b0);
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 10; i++) begin
         s_arith[i] = 5'd31; s_ovr[i] = 1'b0; s_mode[i] = 1'b0;
      end
      drive_frame(10, 1'b0);
      checks++;
      if (acc_out !== 8'h7F || sat_out !== 1'b1) begin
         errors++;
         $display("FAIL sat_pos_const: acc=%h sat=%b, expected 7f 1", acc_out, sat_out);
      end
      collect_result("sat_pos", 0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         s_arith[i] = 5'b10000; s_ovr[i] = 1'b1; s_mode[i] = 1'b1;
      end
      drive_frame(10, 1'b0);
      checks++;
      if (acc_out !== 8'h80 || sat_out !== 1'b1 || ovr_cnt_out !== 4'd10) begin
         errors++;
         $display("FAIL sat_neg_const: acc=%h sat=%b ovr=%0d, expected 80 1 10",
                  acc_out, sat_out, ovr_cnt_out);
      end
      collect_result("sat_neg", 0, 1'b0);
   endtask

   task automatic test_back_to_back_gaps();
      for (int i = 0; i < 7; i++) begin
         s_arith[i] = 5'($urandom);
         s_ovr[i]   = 1'($urandom);
         s_mode[i]  = 1'($urandom);
      end
      drive_frame(7, 1'b1);
      collect_result("gaps", 3, 1'b1);
      // A start in the cycle after the handshake must be accepted.
      start = 1'b1; len_in = 4'd2;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL restart_after_done: ready=%b, expected 1", ready_out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_midframe();
      @(negedge clk);
      start = 1'b1; len_in = 4'd5;
      @(negedge clk);
      start = 1'b0;
      valid = 1'b1; arith = 5'd5; ovr = 1'b1; mode = 1'b0;
      @(negedge clk);
      arith = 5'd6;
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (acc_out !== 8'd11 || ovr_cnt_out !== 4'd2) begin
         errors++;
         $display("FAIL partial_frame: acc=%0d ovr=%0d, expected 11 2", acc_out, ovr_cnt_out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_idle_zero("mid_reset");
      s_arith[0] = 5'd9; s_ovr[0] = 1'b0; s_mode[0] = 1'b0;
      drive_frame(1, 1'b0);
      checks++;
      if (acc_out !== 8'd9 || ovr_cnt_out !== 4'd0) begin
         errors++;
         $display("FAIL after_reset_const: acc=%0d ovr=%0d, expected 9 0", acc_out, ovr_cnt_out);
      end
      collect_result("after_reset", 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len_in = 4'd0; valid = 1'b0;
      arith = 5'd0; ovr = 1'b0; mode = 1'b0; ready_in = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_saturate();
      test_back_to_back_gaps();
      test_reset_midframe();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arith_accum.md
# arith_accum

Sequential accumulator stage directly downstream of the programmable adder/subtractor. Consumes one `{result, overflow, mode}` sample per cycle over a valid/ready handshake and sums a programmed number of samples into a saturating signed accumulator. It also counts how many samples carried the overflow flag, then presents the frame result on an output valid/ready handshake.

## Interface
- `DATA_WD`, 4: operand width of the upstream add/sub; sample width is `DATA_WD+1`.
- `ACC_WD`, 12: signed accumulator width; `ACC_WD > DATA_WD+1`.
- `CNT_WD`, 4: width of the frame length and the overflow counter.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst_n`, in, 1: synchronous, active-low reset.
- `i_start`, in, 1: frame start request; sampled only in IDLE.
- `i_len`, in, `CNT_WD`: samples per frame; latched on an accepted start.
- `i_valid`, in, 1: upstream sample valid.
- `o_ready`, out, 1: block accepts a sample.
- `i_arith`, in, `DATA_WD+1`: upstream arithmetic result.
- `i_ovr`, in, 1: upstream overflow flag for this sample.
- `i_mode`, in, 1: mode the sample was produced with (0 = add, 1 = sub).
- `o_valid`, out, 1: frame result valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_acc`, out, `ACC_WD`: signed frame sum.
- `o_sat`, out, 1: the accumulator saturated at least once in the frame.
- `o_ovr_cnt`, out, `CNT_WD`: number of accepted samples with `i_ovr = 1`; wraps modulo `2^CNT_WD`.
- `o_busy`, out, 1: high in ACCUM and DONE.

## Operation
States: IDLE, ACCUM, DONE.

**IDLE**
- `o_ready = 0`, `o_valid = 0`.
- `i_start = 1` with `i_len != 0`: latch `i_len`, clear the accumulator, `o_sat`, `o_ovr_cnt` and the sample counter, then go to ACCUM.
- `i_start` with `i_len = 0` is ignored; the block stays in IDLE.

**ACCUM**
- `o_ready = 1`.
- An accept (`i_valid & o_ready`) performs three updates:
  - accumulator ← `sat(acc + ext(i_arith))`;
  - `o_ovr_cnt += i_ovr`;
  - sample counter increments.
- Accepting sample number `len` moves the block to DONE.

**DONE**
- `o_valid = 1`; `o_acc`, `o_sat` and `o_ovr_cnt` are held stable.
- `o_valid & i_ready` returns the block to IDLE.

Arithmetic rules:
- Sign extension `ext()`:
  - `i_mode = 0`: `i_arith` is unsigned and zero-extended.
  - `i_mode = 1`: `i_arith` is two's complement and sign-extended.
- Computation: the sum is formed in `ACC_WD+1` bits, then clamped to `[-2^(ACC_WD-1), 2^(ACC_WD-1)-1]`.
- A clamp sets `o_sat`, which stays set until the next accepted start.

Boundary conditions:
- `i_start` in ACCUM or DONE is ignored; no restart or queueing.
- Result handshake and `i_start` in the same cycle: the start is ignored because the block is still in DONE. A new start is accepted from the following cycle.
- Changes on `i_len` after latching have no effect on the current frame.
- `i_valid` gaps stall accumulation with no state change.
- Reset mid-frame or in DONE: on the sampled edge, return to IDLE, clear all registers, and drop any partial frame.

## Timing
- Reset values:
  - `o_ready = 0`, `o_valid = 0`, `o_busy = 0`;
  - `o_acc = 0`, `o_sat = 0`, `o_ovr_cnt = 0`;
  - state = IDLE.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- `i_start` accepted at edge N: `o_ready = 1` from cycle N+1.
- Throughput: one sample per cycle with no bubbles.
- Last sample accepted at edge M: `o_valid = 1` and final `o_acc` visible in cycle M+1.
- Minimum frame length, start to result: `len + 1` cycles. Result handshake at edge K: IDLE from cycle K+1.

## Structure
- Package `arith_pkg`:
  - state enum `acc_state_t` (IDLE, ACCUM, DONE);
  - localparams for the saturation limits derived from `ACC_WD`;
  - mode encoding constants `MODE_ADD = 0`, `MODE_SUB = 1`.
- Sub-module `arith_sat_add`:
  - combinational, parameterised on `ACC_WD`;
  - inputs: accumulator and extended sample;
  - outputs: clamped sum and a saturate flag.
- The top holds the FSM, counters and handshakes.

## Test plan
All cases use `DATA_WD = 4`, `ACC_WD = 8`, `CNT_WD = 4`.
1. Reset held 2 cycles, then released → all outputs 0, IDLE, `o_ready = 0`; `i_start` with `i_len = 0` → stays IDLE, `o_busy = 0`.
2. `len = 3`, mode 0, samples 17, 30, 3 with `i_ovr` = 1, 1, 0 back-to-back → `o_valid` 1 cycle after third accept, `o_acc = 50`, `o_sat = 0`, `o_ovr_cnt = 2`.
3. `len = 2`, mode 1, samples `5'b11101` (−3) and `5'b00100` (+4) → `o_acc = 1`; mixed frame mode 0 value 16 then mode 1 `5'b10000` (−16) → `o_acc = 0`.
4. `len = 10`, mode 0, all 31 → `o_acc = 127`, `o_sat = 1`; `len = 10`, mode 1, all `5'b10000` → `o_acc = −128` (`8'h80`), `o_sat = 1`.
5. Backpressure, three parts:
   - random `i_valid` gaps: the result equals the gap-free result;
   - `i_ready = 0` for 3 cycles in DONE: outputs stable and `o_ready = 0`;
   - `i_start` pulsed in DONE and in the handshake cycle: ignored.
6. Reset asserted after 2 of 5 samples → IDLE with all outputs 0 next cycle; a new `len = 1` frame with sample 9 → `o_acc = 9`, `o_ovr_cnt = 0`.
